// File: rtl/adc_spi_reader.sv
// SPI master that clocks one MSB-first conversion frame out of the radar ADC per Start.
// Emits the low DataBits of the frame with a one-cycle Valid strobe, then enforces a quiet gap.
module adc_spi_reader #(
    parameter int ClkDiv      = 2,
    parameter int FrameBits   = 16,
    parameter int DataBits    = 12,
    parameter int QuietCycles = 8
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                Start,
    output logic                ADC_nCS,
    output logic                ADC_SClk,
    input  logic                ADC_Data,
    output logic [DataBits-1:0] Data,
    output logic                Valid,
    output logic                Busy,
    output logic                Overrun
);
    localparam int DW = $clog2(ClkDiv + 1);
    localparam int BW = $clog2(FrameBits + 1);
    localparam int QW = $clog2(QuietCycles + 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(ClkDiv - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FrameBits - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QuietCycles - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          div_q, div_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [QW-1:0]          quiet_q, quiet_d;
    logic [FrameBits-1:0]   shift_q, shift_d;
    logic                   adc_data_q;
    logic                   ncs_q, ncs_d;
    logic                   sclk_q, sclk_d;
    logic [DataBits-1:0]    data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        quiet_d   = quiet_q;
        shift_d   = shift_q;
        ncs_d     = ncs_q;
        sclk_d    = sclk_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        overrun_d = Start & busy_q;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Sample on the edge that raises SClk: data settled a half-period ago.
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[FrameBits-2:0], adc_data_q};
                    end else if (bit_q == BIT_LAST) begin
                        ncs_d   = 1'b1;
                        data_d  = shift_q[DataBits-1:0];
                        valid_d = 1'b1;
                        quiet_d = '0;
                        state_d = QUIET;
                    end else begin
                        bit_d  = bit_q + BW'(1);
                        sclk_d = 1'b0;
                    end
                end
            end
            QUIET: begin
                if (quiet_q == QUIET_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    quiet_d = quiet_q + QW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            quiet_q    <= '0;
            shift_q    <= '0;
            adc_data_q <= 1'b0;
            ncs_q      <= 1'b1;
            sclk_q     <= 1'b1;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            quiet_q    <= quiet_d;
            shift_q    <= shift_d;
            adc_data_q <= ADC_Data;
            ncs_q      <= ncs_d;
            sclk_q     <= sclk_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign ADC_nCS  = ncs_q;
    assign ADC_SClk = sclk_q;
    assign Data     = data_q;
    assign Valid    = valid_q;
    assign Busy     = busy_q;
    assign Overrun  = overrun_q;
endmodule
